// File: rtl/keyed_lut.sv
// keyed_lut: small associative lookup table with a registered,
// valid/ready response stage.
// The table holds NR_KEY entries of {valid, key, data}. A lookup returns
// the data of the lowest-index valid entry whose key matches, or the
// caller-supplied default on a miss. Lookups see the table contents as they
// were before any write or clear in the same cycle.
// Optional build macro: KEYED_LUT_STATS_EN adds saturating hit/miss counters.
module keyed_lut #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(NR_KEY)-1:0]   wr_idx,
  input  logic [KEY_LEN-1:0]          wr_key,
  input  logic [DATA_LEN-1:0]         wr_data,
  input  logic                        wr_vld,
  input  logic                        clr,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [KEY_LEN-1:0]          req_key,
  input  logic [DATA_LEN-1:0]         default_out,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_LEN-1:0]         resp_data,
  output logic                        resp_hit,
  output logic [$clog2(NR_KEY)-1:0]   resp_idx
`ifdef KEYED_LUT_STATS_EN
  ,
  output logic [15:0]                 hit_cnt,
  output logic [15:0]                 miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NR_KEY);
  localparam logic [IDX_W:0] NR_KEY_W = (IDX_W + 1)'(NR_KEY);

  logic [NR_KEY-1:0]   vld_r;
  logic [KEY_LEN-1:0]  key_mem [NR_KEY];
  logic [DATA_LEN-1:0] data_mem [NR_KEY];

  logic                wr_ok_s;
  logic                accept_s;
  logic                hit_s;
  logic [IDX_W-1:0]    idx_s;
  logic [DATA_LEN-1:0] hit_data_s;

  // The response register can always take a new result once it is empty or
  // being drained this cycle, which gives one lookup per cycle back to back.
  assign req_ready = !resp_valid || resp_ready;
  assign accept_s  = req_valid && req_ready;

  // Writes to indices beyond the table are dropped; clr beats any write.
  assign wr_ok_s = wr_en && !clr && ({1'b0, wr_idx} < NR_KEY_W);

  // Priority match: scan from the top so the lowest matching index wins.
  always_comb begin
    hit_s = 1'b0;
    idx_s = {IDX_W{1'b0}};
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (vld_r[i] && (key_mem[i] == req_key)) begin
        hit_s = 1'b1;
        idx_s = IDX_W'(i);
      end else begin
        hit_s = hit_s;
      end
    end
    if (hit_s) begin
      hit_data_s = data_mem[idx_s];
    end else begin
      hit_data_s = default_out;
    end
  end

  // Per-entry valid bits: cleared by reset or clr, otherwise set by a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= {NR_KEY{1'b0}};
    end else if (clr) begin
      vld_r <= {NR_KEY{1'b0}};
    end else if (wr_ok_s) begin
      vld_r[wr_idx] <= wr_vld;
    end
  end

  // Key/data storage; contents only matter while the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      key_mem[wr_idx]  <= wr_key;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Output register: capture on acceptance, hold while stalled, drop when
  // drained. Later table updates never touch a captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_idx   <= {IDX_W{1'b0}};
      resp_data  <= {DATA_LEN{1'b0}};
    end else if (accept_s) begin
      resp_valid <= 1'b1;
      resp_hit   <= hit_s;
      resp_idx   <= idx_s;
      resp_data  <= hit_data_s;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef KEYED_LUT_STATS_EN
  // Saturating increment so long runs never wrap back to small values.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'h0001;
    end
  endfunction

  // Lookup statistics, split by outcome; clr restarts both counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else if (clr) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else if (accept_s && hit_s) begin
      hit_cnt  <= sat_inc(hit_cnt);
    end else if (accept_s) begin
      miss_cnt <= sat_inc(miss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_keyed_lut.sv
// Scoreboard bench for keyed_lut: the driver pushes the hand-computed
// response at each accepted lookup; a monitor pops and compares whenever a
// response is handed over (resp_valid && resp_ready).
module tb_keyed_lut;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [3:0]  wr_key;
  logic [31:0] wr_data;
  logic        wr_vld;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_key;
  logic [31:0] default_out;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic [1:0]  resp_idx;
`ifdef KEYED_LUT_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
    logic [1:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  keyed_lut dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data), .wr_vld(wr_vld),
    .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .default_out(default_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_hit(resp_hit), .resp_idx(resp_idx)
`ifdef KEYED_LUT_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every handed-over response with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL resp_unexpected: got data=%0h hit=%0b idx=%0d with nothing expected",
                 resp_data, resp_hit, resp_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp{data,hit,idx}", {29'd0, resp_data, resp_hit, resp_idx},
              {29'd0, e.data, e.hit, e.idx});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] idx, input logic [3:0] key,
                       input logic [31:0] data, input logic vld);
    wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_data = data; wr_vld = vld;
    step();
    wr_en = 1'b0;
  endtask

  // Issue one lookup; the expected response is queued at the accepting edge.
  task automatic lookup(input logic [3:0] key, input logic [31:0] dflt,
                        input logic e_hit, input logic [1:0] e_idx, input logic [31:0] e_data);
    int n;
    exp_t e;
    req_valid = 1'b1; req_key = key; default_out = dflt;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) begin
        e.data = e_data; e.hit = e_hit; e.idx = e_idx;
        exp_q.push_back(e);
        break;
      end
      n++;
      if (n > 20) begin
        n_checks++;
        n_err++;
        $display("FAIL accept_timeout: req_ready stayed %0b, required 1", req_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = 2'd0; wr_key = 4'h0; wr_data = 32'h0; wr_vld = 1'b0;
    clr = 1'b0; req_valid = 1'b0; req_key = 4'h0; default_out = 32'h0; resp_ready = 1'b1;
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_fields", {29'd0, resp_data, resp_hit, resp_idx}, 64'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Basic hit and miss
    write(2'd1, 4'h3, 32'hAA, 1'b1);
    lookup(4'h3, 32'h0, 1'b1, 2'd1, 32'hAA);
    lookup(4'h7, 32'hDEAD, 1'b0, 2'd0, 32'hDEAD);

    // Duplicate keys resolve to the lowest valid index
    write(2'd0, 4'h5, 32'h1, 1'b1);
    write(2'd2, 4'h5, 32'h2, 1'b1);
    lookup(4'h5, 32'h0, 1'b1, 2'd0, 32'h1);
    write(2'd0, 4'h5, 32'h1, 1'b0);
    lookup(4'h5, 32'h0, 1'b1, 2'd2, 32'h2);
    // back-to-back pair
    lookup(4'h3, 32'h0, 1'b1, 2'd1, 32'hAA);
    lookup(4'h5, 32'h0, 1'b1, 2'd2, 32'h2);
    step();

    // Stall: response must hold, even while its entry is invalidated
    resp_ready = 1'b0;
    lookup(4'h3, 32'h0, 1'b1, 2'd1, 32'hAA);
    req_valid = 1'b1; req_key = 4'h3; default_out = 32'hBEEF;
    wr_en = 1'b1; wr_idx = 2'd1; wr_key = 4'h3; wr_data = 32'hAA; wr_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_resp", {28'd0, resp_valid, resp_data, resp_hit, resp_idx},
            {28'd0, 1'b1, 32'hAA, 1'b1, 2'd1});
      @(posedge clk);
      #1;
      wr_en = 1'b0;
    end
    resp_ready = 1'b1;
    lookup(4'h3, 32'hBEEF, 1'b0, 2'd0, 32'hBEEF);
    step();

    // Read-before-write and clr priority
    clr = 1'b1; step(); clr = 1'b0;
    wr_en = 1'b1; wr_idx = 2'd1; wr_key = 4'h3; wr_data = 32'h55; wr_vld = 1'b1;
    lookup(4'h3, 32'h1234, 1'b0, 2'd0, 32'h1234);
    wr_en = 1'b0;
    lookup(4'h3, 32'h0, 1'b1, 2'd1, 32'h55);
    clr = 1'b1;
    wr_en = 1'b1; wr_idx = 2'd2; wr_key = 4'h9; wr_data = 32'h99; wr_vld = 1'b1;
    step();
    clr = 1'b0; wr_en = 1'b0;
    lookup(4'h9, 32'h77, 1'b0, 2'd0, 32'h77);
    lookup(4'h3, 32'h78, 1'b0, 2'd0, 32'h78);
    step();

    // Asynchronous reset while a response is pending
    write(2'd0, 4'h1, 32'h11, 1'b1);
    resp_ready = 1'b0;
    lookup(4'h1, 32'h0, 1'b1, 2'd0, 32'h11);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_resp_fields", {29'd0, resp_data, resp_hit, resp_idx}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    resp_ready = 1'b1;
    step();
    lookup(4'h1, 32'h42, 1'b0, 2'd0, 32'h42);
    step();

    // Hit/miss statistics
    clr = 1'b1; step(); clr = 1'b0;
    write(2'd0, 4'h1, 32'h11, 1'b1);
    lookup(4'h1, 32'h0, 1'b1, 2'd0, 32'h11);
    lookup(4'h1, 32'h0, 1'b1, 2'd0, 32'h11);
    lookup(4'h2, 32'h5, 1'b0, 2'd0, 32'h5);
    lookup(4'h1, 32'h0, 1'b1, 2'd0, 32'h11);
    lookup(4'h2, 32'h6, 1'b0, 2'd0, 32'h6);
    step(); step();
`ifdef KEYED_LUT_STATS_EN
    check("hit_cnt", 64'(hit_cnt), 64'd3);
    check("miss_cnt", 64'(miss_cnt), 64'd2);
`endif
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
